// File: rtl/riscv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder/loader.
// Opcodes, request classes, error codes, FSM states and the halt word.
package riscv_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_ITYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CLASS = 2'd1;
  localparam logic [1:0] ERR_IMM   = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  localparam logic [31:0] HALT_WORD = 32'h0000_0063;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  // A 13-bit immediate fits 12 signed bits when bit 12 mirrors bit 11.
  function automatic logic imm_fits12(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational field-to-word encoder for LOAD/STORE/RTYPE/ITYPE/BRANCH.
// Reports illegal class and immediate range/alignment faults.
module instr_field_encoder
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic [1:0]  enc_err
);

  logic shift_op;
  logic [6:0] f7;

  assign shift_op = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign f7 = {1'b0, funct7_5, 5'b00000};

  // Build the word per class; shifts keep only the shamt in imm[4:0].
  always_comb begin
    word    = '0;
    enc_err = ERR_NONE;
    unique case (cls)
      CLS_LOAD: begin
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        if (!imm_fits12(imm)) enc_err = ERR_IMM;
      end
      CLS_STORE: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        if (!imm_fits12(imm)) enc_err = ERR_IMM;
      end
      CLS_RTYPE: begin
        word = {f7, rs2, rs1, funct3, rd, OP_RTYPE};
      end
      CLS_ITYPE: begin
        if (shift_op)
          word = {f7, imm[4:0], rs1, funct3, rd, OP_ITYPE};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
        if (!imm_fits12(imm)) enc_err = ERR_IMM;
      end
      CLS_BRANCH: begin
        word = {imm[12], imm[10:5], rs2, rs1,
                funct3, imm[4:1], imm[11], OP_BRANCH};
        if (imm[0]) enc_err = ERR_IMM;
      end
      default: begin
        enc_err = ERR_CLASS;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and streams them into imem via a FIFO.
// Optional macro HALT_APPEND_EN appends a beq x0,x0,0 after the program.
module instr_encoder_loader
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int IMEM_WORDS = 256,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7_5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int PW = ADDR_W + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_e state, nstate;

  logic [PW-1:0] ptr;
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] rd_idx, wr_idx;
  logic [CW-1:0] cnt;

  logic [31:0] enc_word;
  logic [1:0]  enc_err;

  logic empty, full, accept, push, pop;
  logic ovf, ovf_hit, flush, wr_halt, begin_load;

  instr_field_encoder u_enc (
    .cls      (req_class),
    .funct3   (req_funct3),
    .funct7_5 (req_funct7_5),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .word     (enc_word),
    .enc_err  (enc_err)
  );

  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign ovf        = (ptr == PW'(IMEM_WORDS));
  assign req_ready  = (state == S_LOAD) && !full;
  assign accept     = req_valid && req_ready;
  assign begin_load = (state == S_IDLE) && start;
  assign push       = accept && (enc_err == ERR_NONE) && !flush;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

`ifdef HALT_APPEND_EN
  logic halt_done;

  // Remembers that the trailing halt word has been issued.
  always_ff @(posedge clk) begin
    if (rst || begin_load) halt_done <= 1'b0;
    else if (wr_halt)      halt_done <= 1'b1;
  end
`endif

  // Next state, write issue and overflow detection.
  always_comb begin
    nstate  = state;
    pop     = 1'b0;
    wr_halt = 1'b0;
    ovf_hit = 1'b0;
    flush   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nstate = S_LOAD;
      end
      S_LOAD: begin
        if (!empty) begin
          if (ovf) begin
            ovf_hit = 1'b1;
            flush   = 1'b1;
            nstate  = S_DONE;
          end else begin
            pop = 1'b1;
          end
        end
        if (!ovf_hit && accept && req_last)
          nstate = S_DRAIN;
      end
      S_DRAIN: begin
        if (!empty) begin
          if (ovf) begin
            ovf_hit = 1'b1;
            flush   = 1'b1;
            nstate  = S_DONE;
          end else begin
            pop = 1'b1;
          end
        end else begin
`ifdef HALT_APPEND_EN
          if (halt_done) begin
            nstate = S_DONE;
          end else if (ovf) begin
            ovf_hit = 1'b1;
            nstate  = S_DONE;
          end else begin
            wr_halt = 1'b1;
          end
`else
          nstate = S_DONE;
`endif
        end
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Write pointer: restarts at BASE_ADDR, advances once per write.
  always_ff @(posedge clk) begin
    if (rst || begin_load)  ptr <= PW'(BASE_ADDR);
    else if (pop || wr_halt) ptr <= ptr + 1'b1;
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= enc_word;
  end

  // FIFO indices and occupancy; flush drops everything queued.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered imem write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= pop || wr_halt;
      if (pop) begin
        imem_addr  <= ptr[ADDR_W-1:0];
        imem_wdata <= mem[rd_idx];
      end else if (wr_halt) begin
        imem_addr  <= ptr[ADDR_W-1:0];
        imem_wdata <= HALT_WORD;
      end
    end
  end

  // Sticky error; the first code seen is held until the next start.
  always_ff @(posedge clk) begin
    if (rst || begin_load) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (!err) begin
      if (accept && enc_err != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= enc_err;
      end else if (ovf_hit) begin
        err      <= 1'b1;
        err_code <= ERR_OVF;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (IMEM_WORDS=4).
// Expectations follow HALT_APPEND_EN when it is defined.
module tb_instr_encoder_loader;

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;

`ifdef HALT_APPEND_EN
  localparam int HALT = 1;
`else
  localparam int HALT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_class = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_funct7_5 = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [12:0] req_imm = '0;
  logic        req_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_bad = 0;
  int wr_n = 0;
  int done_cnt = 0;
  int d0;
  logic [7:0]  wa [64];
  logic [31:0] wd [64];
  vec_t tv [8];

  instr_encoder_loader #(
    .ADDR_W(8), .IMEM_WORDS(4), .BASE_ADDR(0), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_funct3(req_funct3),
    .req_funct7_5(req_funct7_5), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Log writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (imem_we && wr_n < 64) begin
      wa[wr_n] = imem_addr;
      wd[wr_n] = imem_wdata;
      wr_n = wr_n + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  function automatic vec_t mk(
    input logic [2:0] cls, input logic [2:0] f3, input logic f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [12:0] imm, input logic [31:0] word,
    input logic [1:0] code);
    vec_t v;
    v.cls = cls; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.imm = imm; v.word = word; v.code = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_prog();
    @(negedge clk);
    wr_n = 0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic last, output bit ok);
    req_class = v.cls; req_funct3 = v.f3; req_funct7_5 = v.f7;
    req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_imm = v.imm; req_last = last; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) ok = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int en;
    vec_t lw, sw, sub, bad_b, bad_l;

    tv[0] = mk(3'd0, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 13'h0008,
               32'h0080A283, 2'd0);
    tv[1] = mk(3'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 13'h1FFF,
               32'hFFF00093, 2'd0);
    tv[2] = mk(3'd3, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 13'h0003,
               32'h40315093, 2'd0);
    tv[3] = mk(3'd2, 3'b000, 1'b0, 5'd7, 5'd8, 5'd9, 13'h0000,
               32'h009403B3, 2'd0);
    tv[4] = mk(3'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd5, 13'h1FF8,
               32'hFE50AC23, 2'd0);
    tv[5] = mk(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC,
               32'hFE208EE3, 2'd0);
    tv[6] = mk(3'd6, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 13'h0000,
               32'h0, 2'd1);
    tv[7] = mk(3'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1000,
               32'h0, 2'd2);
    lw  = tv[0];
    sw  = mk(3'd1, 3'b010, 1'b0, 5'd0, 5'd2, 5'd6, 13'h000C,
             32'h00612623, 2'd0);
    sub = mk(3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 13'h0000,
             32'h402081B3, 2'd0);
    bad_b = mk(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0003,
               32'h0, 2'd2);
    bad_l = mk(3'd0, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 13'h0800,
               32'h0, 2'd2);

    repeat (2) @(negedge clk);
    chk("reset_outs",
        {22'd0, req_ready, imem_we, imem_addr != 0, imem_wdata != 0,
         busy, done, err, err_code, 1'b0}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_prog();
      chk($sformatf("err_clr[%0d]", i), {31'd0, err}, 32'd0);
      drive(tv[i], 1'b1, ok);
      chk($sformatf("accept[%0d]", i), {31'd0, ok}, 32'd1);
      wait_done(ok);
      chk($sformatf("done[%0d]", i), {31'd0, ok}, 32'd1);
      en = (tv[i].code == 2'd0 ? 1 : 0) + HALT;
      chk($sformatf("nwr[%0d]", i), wr_n, en);
      if (tv[i].code == 2'd0 && wr_n > 0) begin
        chk($sformatf("word[%0d]", i), wd[0], tv[i].word);
        chk($sformatf("addr[%0d]", i), {24'd0, wa[0]}, 32'd0);
      end
      if (HALT == 1 && wr_n == en && en > 0) begin
        chk($sformatf("halt[%0d]", i), wd[en-1], 32'h00000063);
        chk($sformatf("haddr[%0d]", i), {24'd0, wa[en-1]}, en - 1);
      end
      chk($sformatf("err[%0d]", i), {31'd0, err},
          {31'd0, tv[i].code != 2'd0});
      chk($sformatf("code[%0d]", i), {30'd0, err_code},
          {30'd0, tv[i].code});
    end

    start_prog();
    drive(sw, 1'b0, ok);
    drive(sub, 1'b1, ok);
    wait_done(ok);
    chk("two_done", {31'd0, ok}, 32'd1);
    chk("two_nwr", wr_n, 2 + HALT);
    if (wr_n >= 2) begin
      chk("two_w0", wd[0], 32'h00612623);
      chk("two_a0", {24'd0, wa[0]}, 32'd0);
      chk("two_w1", wd[1], 32'h402081B3);
      chk("two_a1", {24'd0, wa[1]}, 32'd1);
    end
    chk("two_err", {31'd0, err}, 32'd0);

    start_prog();
    drive(bad_b, 1'b0, ok);
    drive(bad_l, 1'b0, ok);
    drive(lw, 1'b1, ok);
    wait_done(ok);
    chk("errseq_done", {31'd0, ok}, 32'd1);
    chk("errseq_nwr", wr_n, 1 + HALT);
    if (wr_n >= 1) begin
      chk("errseq_w0", wd[0], 32'h0080A283);
      chk("errseq_a0", {24'd0, wa[0]}, 32'd0);
    end
    chk("errseq_err", {31'd0, err}, 32'd1);
    chk("errseq_code", {30'd0, err_code}, 32'd2);

    start_prog();
    for (int i = 0; i < 6; i++) drive(lw, i == 5, ok);
    wait_done(ok);
    chk("ovf_done", {31'd0, ok}, 32'd1);
    chk("ovf_nwr", wr_n, 4);
    for (int i = 0; i < 4 && i < wr_n; i++)
      chk($sformatf("ovf_a%0d", i), {24'd0, wa[i]}, i);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_code", {30'd0, err_code}, 32'd3);
    chk("ovf_ready", {31'd0, req_ready}, 32'd0);

    start_prog();
    for (int i = 0; i < 3; i++) drive(lw, 1'b0, ok);
    chk("rst_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs",
        {22'd0, req_ready, imem_we, imem_addr != 0, imem_wdata != 0,
         busy, done, err, err_code, 1'b0}, 32'd0);
    rst = 1'b0;
    en = wr_n;
    repeat (6) @(negedge clk);
    chk("rst_nowr", wr_n, en);
    chk("rst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
